// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the RV32M/RV64M
// operation set. The operation is selected by funct3 and takes one step per clock.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - asynchronous active-high reset
//   start  - request; only sampled while busy=0
//   op     - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   srca   - rs1 (multiplicand / dividend)
//   srcb   - rs2 (multiplier / divisor)
//   abort  - cancel the in-flight operation
//   busy   - high from acceptance until done has been issued
//   done   - one-cycle pulse; res is valid in this cycle
//   res    - result; held until the next result is written
//
// Handshake: a request is accepted on a rising edge where start=1, busy=0
// (state IDLE) and abort=0. busy rises after that edge. It stays high through the
// cycle in which done pulses and falls on the following edge. start is ignored
// while busy=1, so the earliest next request is the cycle after done. abort
// forces IDLE at the next edge. It suppresses a pending done and leaves res unchanged.
module muldiv_unit #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srca,
   input  logic [XLEN-1:0] srcb,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] res
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state;
   logic [2:0]          op_r;
   logic [XLEN-1:0]     opb;     // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   prod;    // mul: {acc, multiplier}; div: {rem, quotient}
   logic [CW-1:0]       count;
   logic                neg_r;   // final negate of the selected result

   // Decode of the incoming request
   logic                a_signed, b_signed;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic                b_zero, ovf, early, neg_start;
   logic [XLEN-1:0]     early_res;

   always_comb begin
      a_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      abs_a     = (a_signed && srca[XLEN-1]) ? -srca : srca;
      abs_b     = (b_signed && srcb[XLEN-1]) ? -srcb : srcb;
      b_zero    = (srcb == '0);
      ovf       = ((op == OP_DIV) || (op == OP_REM)) && (srca == MIN_NEG) && (srcb == '1);
      early     = EARLY_OUT && op[2] && (b_zero || ovf);
      // Divide by zero: quotient all ones, remainder is the dividend.
      // Overflow: quotient is the dividend, remainder zero.
      if (b_zero) early_res = op[1] ? srca : '1;
      else        early_res = op[1] ? '0 : srca;
      // The quotient of a divide by zero must stay all ones, so it is never negated.
      case (op)
         OP_MULH:   neg_start = srca[XLEN-1] ^ srcb[XLEN-1];
         OP_MULHSU: neg_start = srca[XLEN-1];
         OP_DIV:    neg_start = (srca[XLEN-1] ^ srcb[XLEN-1]) && !b_zero;
         OP_REM:    neg_start = srca[XLEN-1];
         default:   neg_start = 1'b0;
      endcase
   end

   // One iteration step
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_shift;
   logic                div_ge;
   logic [XLEN-1:0]     div_sub;
   logic [2*XLEN-1:0]   div_next;

   always_comb begin
      mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      mul_next  = {mul_sum, prod[XLEN-1:1]};
      div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      // The true difference is below the divisor, so XLEN bits hold it exactly.
      div_sub   = div_shift[XLEN-1:0] - opb;
      div_next  = div_ge ? {div_sub, prod[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0};
   end

   // Sign fix-up and result selection
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     q_fix, r_fix, fix_res;

   always_comb begin
      prod_fix = neg_r ? -prod : prod;
      q_fix    = neg_r ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      r_fix    = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      if (op_r == OP_MUL)  fix_res = prod_fix[XLEN-1:0];
      else if (!op_r[2])   fix_res = prod_fix[2*XLEN-1:XLEN];
      else if (!op_r[1])   fix_res = q_fix;
      else                 fix_res = r_fix;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_r  <= '0;
         opb   <= '0;
         prod  <= '0;
         count <= '0;
         neg_r <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         res   <= '0;
      end else if (abort) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= op;
                  neg_r <= neg_start;
                  busy  <= 1'b1;
                  if (early) begin
                     res   <= early_res;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     opb   <= abs_b;
                     prod  <= {{XLEN{1'b0}}, abs_a};
                     count <= CW'(XLEN);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               prod  <= op_r[2] ? div_next : mul_next;
               count <= count - CW'(1);
               if (count == CW'(1)) state <= FIX;
            end
            FIX: begin
               res   <= fix_res;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit. Two 32-bit instances share the
// stimulus: one with early-out and one without. An 8-bit early-out instance has its
// own request inputs. Table vectors carry hand-computed results. Hand-written
// sequences cover ignored start, abort, back-to-back, and asynchronous reset.
module tb_muldiv_unit;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          early;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, abort, start8;
   logic [2:0]  op, op8;
   logic [31:0] srca, srcb;
   logic [7:0]  a8, b8;
   logic        busy_e, done_e, busy_n, done_n, busy8, done8;
   logic [31:0] res_e, res_n;
   logic [7:0]  res8;

   int errors = 0;
   int checks = 0;

   vec_t vecs[18];
   vec_t vecs8[4];

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_e (
      .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .abort(abort), .busy(busy_e), .done(done_e), .res(res_e));

   muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_n (
      .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .abort(abort), .busy(busy_n), .done(done_n), .res(res_n));

   muldiv_unit #(.XLEN(8), .EARLY_OUT(1'b1)) u_8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .srca(a8), .srcb(b8),
      .abort(abort), .busy(busy8), .done(done8), .res(res8));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Applies one request to both 32-bit instances and follows them for 40 edges.
   task automatic run32(input vec_t v);
      int e_edge, n_edge, be, bn;
      e_edge = -1; n_edge = -1; be = 0; bn = 0;
      @(negedge clk);
      op = v.op; srca = v.a; srcb = v.b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy_e) be++;
         if (busy_n) bn++;
         if (done_e && e_edge < 0) begin
            e_edge = k;
            check({v.name, " res early"}, res_e, v.exp);
         end
         if (done_n && n_edge < 0) begin
            n_edge = k;
            check({v.name, " res full"}, res_n, v.exp);
         end
         @(posedge clk); #1;
      end
      check({v.name, " done edge early"}, e_edge, v.early ? 0 : 33);
      check({v.name, " done edge full"}, n_edge, 33);
      check({v.name, " busy cycles early"}, be, v.early ? 1 : 34);
      check({v.name, " busy cycles full"}, bn, 34);
   endtask

   task automatic run8(input vec_t v);
      int d_edge, bc;
      d_edge = -1; bc = 0;
      @(negedge clk);
      op8 = v.op; a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (busy8) bc++;
         if (done8 && d_edge < 0) begin
            d_edge = k;
            check({v.name, " res8"}, {24'h0, res8}, v.exp);
         end
         @(posedge clk); #1;
      end
      check({v.name, " done edge8"}, d_edge, v.early ? 0 : 9);
      check({v.name, " busy cycles8"}, bc, v.early ? 1 : 10);
   endtask

   initial begin
      int d_edge, dseen;

      vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul"};
      vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh min"};
      vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu"};
      vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu"};
      vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, "mulh neg"};
      vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div neg"};
      vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem neg"};
      vecs[7]  = '{3'b101, 32'hFFFFFFFE, 32'h00000003, 32'h55555554, 1'b0, "divu"};
      vecs[8]  = '{3'b111, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 1'b0, "remu"};
      vecs[9]  = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div negb"};
      vecs[10] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, "rem negb"};
      vecs[11] = '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, "divu by0"};
      vecs[12] = '{3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1, "rem by0"};
      vecs[13] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div ovf"};
      vecs[14] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem ovf"};
      vecs[15] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1, "div neg by0"};
      vecs[16] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1, "rem neg by0"};
      vecs[17] = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1, "remu by0"};

      vecs8[0] = '{3'b011, 32'hFF, 32'hFF, 32'hFE, 1'b0, "x8 mulhu"};
      vecs8[1] = '{3'b100, 32'h80, 32'hFF, 32'h80, 1'b1, "x8 div ovf"};
      vecs8[2] = '{3'b111, 32'h13, 32'h05, 32'h04, 1'b0, "x8 remu"};
      vecs8[3] = '{3'b000, 32'h10, 32'h11, 32'h10, 1'b0, "x8 mul"};

      // Clock and reset
      rst = 1'b1; start = 1'b0; abort = 1'b0; start8 = 1'b0;
      op = '0; srca = '0; srcb = '0; op8 = '0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {29'h0, busy_e, busy_n, busy8}, 32'h0);
      check("reset done", {29'h0, done_e, done_n, done8}, 32'h0);
      check("reset res e", res_e, 32'h0);
      check("reset res n", res_n, 32'h0);
      check("reset res8", {24'h0, res8}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) run32(vecs[i]);

      // A start pulse after edge 5 of a busy op must not disturb it.
      @(negedge clk);
      op = 3'b000; srca = 32'h7; srcb = 32'hFFFFFFFD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; d_edge = -1;
      for (int k = 0; k < 40; k++) begin
         if (k == 5) begin op = 3'b101; srca = 32'h3; srcb = 32'h1; start = 1'b1; end
         if (k == 6) start = 1'b0;
         if (done_e && d_edge < 0) begin
            d_edge = k;
            check("ignored start res", res_e, 32'hFFFFFFEB);
         end
         @(posedge clk); #1;
      end
      check("ignored start done edge", d_edge, 33);

      // Abort after edge 10: idle at next edge, no done, res kept.
      @(negedge clk);
      op = 3'b101; srca = 32'hFFFFFFFE; srcb = 32'h3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort busy", {31'h0, busy_e}, 32'h0);
      check("abort done", {31'h0, done_e}, 32'h0);
      check("abort res", res_e, 32'hFFFFFFEB);
      check("abort res full", res_n, 32'hFFFFFFEB);
      dseen = 0;
      for (int k = 0; k < 30; k++) begin
         if (done_e || done_n || busy_e) dseen++;
         @(posedge clk); #1;
      end
      check("abort no done later", dseen, 0);

      // abort together with start in IDLE: the request is dropped.
      @(negedge clk);
      op = 3'b000; srca = 32'h3; srcb = 32'h3; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort beats start", {30'h0, busy_e, busy_n}, 32'h0);

      // Back-to-back: start held from the DONE cycle is taken one edge later.
      @(negedge clk);
      op = 3'b000; srca = 32'h7; srcb = 32'hFFFFFFFD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; d_edge = -1;
      for (int k = 0; k < 40 && d_edge < 0; k++) begin
         if (done_e) d_edge = k;
         else begin @(posedge clk); #1; end
      end
      check("b2b first done edge", d_edge, 33);
      op = 3'b011; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      check("b2b not taken in done", {31'h0, busy_e}, 32'h0);
      @(posedge clk); #1;
      check("b2b taken after done", {31'h0, busy_e}, 32'h1);
      start = 1'b0; d_edge = -1;
      for (int k = 0; k < 40; k++) begin
         if (done_e && d_edge < 0) begin
            d_edge = k;
            check("b2b second res", res_e, 32'hFFFFFFFE);
         end
         @(posedge clk); #1;
      end
      check("b2b second done edge", d_edge, 33);

      // Asynchronous reset between edges in the middle of CALC.
      @(negedge clk);
      op = 3'b100; srca = 32'hFFFFFFF9; srcb = 32'h2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      #1 rst = 1'b1;
      #1;
      check("async rst busy", {30'h0, busy_e, busy_n}, 32'h0);
      check("async rst done", {30'h0, done_e, done_n}, 32'h0);
      check("async rst res", res_e, 32'h0);
      check("async rst res full", res_n, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dseen = 0;
      for (int k = 0; k < 30; k++) begin
         if (done_e || busy_e) dseen++;
         @(posedge clk); #1;
      end
      check("async rst stays idle", dseen, 0);

      for (int i = 0; i < 4; i++) run8(vecs8[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit implementing the RV32M/RV64M operation set, selected by funct3.
- Sits beside the integer ALU in the multi-cycle core. The main controller starts it from a new execute state for opcode 0x0C with funct7 = 0000001, then waits for done before the register writeback state.
- Generalises the ALU in width (XLEN) and adds sequential, handshaked operations that the single-cycle ALU cannot do.

Parameters:
- XLEN, 32: operand/result width; any value >= 4. Iteration counter width is clog2(XLEN)+1.
- EARLY_OUT, 1: when 1, divide-by-zero and signed-overflow divides finish without iterating.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srca  in  XLEN  rs1 operand (multiplicand/dividend); sampled with start.
- srcb  in  XLEN  rs2 operand (multiplier/divisor); sampled with start.
- abort  in  1  cancel the in-flight operation.
- busy  out  1  high from acceptance until done is issued.
- done  out  1  one-cycle pulse; res is valid in this cycle.
- res  out  XLEN  result; holds its value until the next accepted start.

Behaviour:
- Reset: rst is asynchronous, active-high. It immediately forces state IDLE, busy=0, done=0, res=0 and clears internal registers, including mid-operation. Release is synchronous to clk.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on start:
  - Latch op.
  - Take absolute values of operands that are signed for this op (MULH: both; MULHSU: srca only; DIV/REM: both).
  - Record result sign and load count=XLEN. busy=1 from the next cycle.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - count decrements; the last step (count=1) -> FIX.
- FIX: negate if required, then select the result.
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - Quotient is negative when dividend and divisor signs differ. Remainder takes the dividend's sign.
  - Write res; -> DONE.
- DONE: done=1 for exactly one cycle, busy=1; -> IDLE. busy drops the cycle after done.
- Latency: start sampled at edge 0 -> done high between edges XLEN+1 and XLEN+2 -> busy=0 after edge XLEN+2.
- EARLY_OUT=1 special cases go IDLE -> DONE at edge 0, with res written at edge 0 (done high between edges 0 and 1):
  - Divide by zero: DIV/DIVU res = all ones; REM/REMU res = srca.
  - Overflow (DIV/REM, srca = -2^(XLEN-1), srcb = -1): DIV res = srca; REM res = 0.
- EARLY_OUT=0: the same special-case results come out of the normal iteration and sign fix-up, with full latency.
- start while busy=1 is ignored; operands are not resampled.
- abort while busy=1 (including DONE): -> IDLE at the next edge. done is suppressed if not already high, res is unchanged, busy=0 after that edge.
- abort with start in IDLE: abort wins; the request is not accepted.
- Back-to-back: start may be asserted in the cycle after done (busy=0). It is never accepted in the DONE cycle itself.
- Arithmetic is modulo 2^XLEN. MUL low half is identical for all signedness.

Test Plan:
- MUL, XLEN=32, 7 * 0xFFFFFFFD -> res=0xFFFFFFEB; done high exactly between edges 33 and 34; busy=1 for 34 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/3 -> 0x55555554; REMU same -> 2.
- EARLY_OUT=1:
  - DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, each with done one cycle after start.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - Repeat with EARLY_OUT=0: identical results at full latency.
- Control:
  - start pulsed at cycle 5 of a busy op -> ignored, original result returned.
  - abort at cycle 10 -> busy=0 next edge, no done, res unchanged.
  - rst asserted mid-CALC (asynchronous, between edges) -> busy=0, done=0, res=0 before the next edge.
- XLEN=8 instance: MULHU 0xFF*0xFF -> 0xFE, done between edges 9 and 10; DIV 0x80/0xFF -> 0x80 early-out.
